trajectory_accumulator: RTL and testbench
=========================================

TRAJECTORY_ACCUMULATOR -- requirements
Module: trajectory_accumulator

Interface
REQ-001 SHALL have parameter N, default 64, data width of all fixed-point quantities.
REQ-002 SHALL have parameter TARGET_FX, default 188_000_000_000_000, target altitude (188 km) in 1e-9 m units.
REQ-003 SHALL have parameter MAX_SAMPLES, default 1_000_000, sample limit before timeout.
REQ-004 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 SHALL have port resetb  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  launch/restart request, sampled each cycle.
REQ-007 SHALL have port in_valid  input  1  qualifies the fraction inputs for one cycle.
REQ-008 SHALL have port fraction_Altitude  input  N  unsigned per-sample altitude increment, 1e-9 m.
REQ-009 SHALL have port fraction_Distance  input  N  unsigned per-sample ground-distance increment, 1e-9 m.
REQ-010 SHALL have port gravity_loss  input  N  unsigned per-sample altitude decrement, 1e-9 m.
REQ-011 SHALL have port current_Altitude  output  N  accumulated altitude, 1e-9 m.
REQ-012 SHALL have port total_Distance  output  N  accumulated ground distance, 1e-9 m.
REQ-013 SHALL have port sample_count  output  32  accepted samples since last start.
REQ-014 SHALL have port state  output  2  FSM state encoding.
REQ-015 SHALL have port done  output  1  high while state is DONE.
REQ-016 SHALL have port overflow  output  1  sticky saturation flag.

Function
REQ-017 SHALL implement states IDLE=0, ASCEND=1, DONE=2, TIMEOUT=3.
REQ-018 SHALL move IDLE->ASCEND on start, clearing current_Altitude, total_Distance, sample_count, overflow in that same edge.
REQ-019 SHALL, in DONE or TIMEOUT, treat start exactly as in IDLE (clear and enter ASCEND); start in ASCEND SHALL be ignored.
REQ-020 SHALL accept a sample only when state==ASCEND and in_valid==1; all outputs SHALL hold otherwise.
REQ-021 SHALL, on an accepted sample, register current_Altitude <= current_Altitude + fraction_Altitude - gravity_loss, with results visible one cycle after the in_valid cycle.
REQ-022 SHALL clamp the altitude to 0 when the subtraction underflows (no flag).
REQ-023 SHALL, on an accepted sample, register total_Distance <= total_Distance + fraction_Distance.
REQ-024 SHALL saturate either sum at 2^N-1 on carry-out and set overflow, which stays set until the next start or reset.
REQ-025 SHALL increment sample_count by 1 per accepted sample.
REQ-026 SHALL enter DONE on the same edge that the new altitude >= TARGET_FX.
REQ-027 SHALL enter TIMEOUT on the same edge that the new sample_count == MAX_SAMPLES and the target is not reached; DONE SHALL win if both hold.
REQ-028 SHALL assert done combinationally from state==DONE, with no extra latency.

Reset
REQ-029 SHALL, while resetb==0, force state=IDLE and current_Altitude, total_Distance, sample_count, overflow, done to 0, regardless of the clock.
REQ-030 SHALL abandon a mid-ASCEND run on reset, with no residue after resetb returns high.

Structure
REQ-031 SHALL take state encodings, the 1e9 fixed-point scale constant and the TARGET_FX default from a shared trajectory package.
REQ-032 SHALL implement the saturating add/subtract as one sub-module, sat_accum, instantiated twice (altitude with subtract enabled, distance without).

Verification
REQ-033 SHALL cover: start, then 3 valid samples fracA=10e9, grav=1e9, fracD=5e9 -> altitude 27e9, distance 15e9, count 3, state ASCEND.
REQ-034 SHALL cover: altitude 2e9, sample fracA=0, grav=5e9 -> altitude 0, overflow 0.
REQ-035 SHALL cover: altitude TARGET_FX-1, sample fracA=1, grav=0 -> altitude TARGET_FX, state DONE, done=1 next cycle; further valid samples are ignored.
REQ-036 SHALL cover: MAX_SAMPLES=4 with the 4th sample also reaching the target -> DONE, not TIMEOUT; a separate run with no target reached -> TIMEOUT after the 4th sample.
REQ-037 SHALL cover: distance 2^N-2, fracD=5 -> distance 2^N-1, overflow=1; overflow stays set through later samples and clears on start.
REQ-038 SHALL cover: resetb pulsed low mid-ASCEND between clock edges -> all outputs 0 and IDLE immediately; a new start yields a clean run.

Source files
------------

// File: rtl/trajectory_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trajectory_accumulator_pkg
// Brief    : Shared trajectory types and constants. It holds the FSM state
//            encoding, the 1e9 fixed-point scale and the default target
//            altitude.
// Revision : 1.0 - initial release
// ============================================================================
package trajectory_accumulator_pkg;

    // One metre expressed in the 1e-9 m fixed-point unit.
    localparam logic [63:0] FX_SCALE = 64'd1_000_000_000;

    // Default target altitude: 188 km.
    localparam logic [63:0] TARGET_FX_DEFAULT = 64'd188_000 * FX_SCALE;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ASCEND  = 2'd1,
        S_DONE    = 2'd2,
        S_TIMEOUT = 2'd3
    } traj_state_t;

endpackage
`default_nettype wire

// File: rtl/trajectory_accumulator_sat_accum.sv
`default_nettype none
// ============================================================================
// Module   : sat_accum
// Brief    : Combinational saturating accumulate step:
//            result = acc + add (- sub).
//            The result clamps to all-ones on carry-out and sets saturated.
//            When SUBTRACT is set, a negative result clamps to zero and the
//            flag stays low.
// Revision : 1.0 - initial release
// ============================================================================
module sat_accum #(
    parameter int W        = 64,
    parameter bit SUBTRACT = 1'b0
) (
    input  logic [W-1:0] acc,
    input  logic [W-1:0] add,
    input  logic [W-1:0] sub,
    output logic [W-1:0] result,
    output logic         saturated
);

    // One extra bit holds the carry of acc + add, which is at most 2^(W+1)-2.
    logic [W:0] sum;
    assign sum = {1'b0, acc} + {1'b0, add};

    if (SUBTRACT) begin : g_sub
        logic [W:0] diff;
        assign diff = sum - {1'b0, sub};

        // Underflow is checked before carry-out, because diff is only
        // meaningful when sum >= sub.
        always_comb begin
            result    = diff[W-1:0];
            saturated = 1'b0;
            if (sum < {1'b0, sub}) begin
                result = '0;
            end else if (diff[W]) begin
                result    = '1;
                saturated = 1'b1;
            end
        end
    end else begin : g_add
        logic unused_sub;
        assign unused_sub = ^sub;

        // Pure add: the carry bit alone decides saturation.
        always_comb begin
            result    = sum[W-1:0];
            saturated = 1'b0;
            if (sum[W]) begin
                result    = '1;
                saturated = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/trajectory_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : trajectory_accumulator
// Brief    : Accumulates per-sample altitude and ground-distance increments
//            during an ascent. It reports DONE when the target altitude is
//            reached and TIMEOUT when the sample budget runs out first.
//            Both sums saturate, and a sticky overflow flag records it.
// Revision : 1.0 - initial release
// ============================================================================
module trajectory_accumulator
    import trajectory_accumulator_pkg::*;
#(
    parameter int          N           = 64,
    parameter logic [63:0] TARGET_FX   = TARGET_FX_DEFAULT,
    parameter int unsigned MAX_SAMPLES = 1_000_000
) (
    input  logic         clk,
    input  logic         resetb,
    input  logic         start,
    input  logic         in_valid,
    input  logic [N-1:0] fraction_Altitude,
    input  logic [N-1:0] fraction_Distance,
    input  logic [N-1:0] gravity_loss,
    output logic [N-1:0] current_Altitude,
    output logic [N-1:0] total_Distance,
    output logic [31:0]  sample_count,
    output logic [1:0]   state,
    output logic         done,
    output logic         overflow
);

    localparam logic [N-1:0] TARGET_N = N'(TARGET_FX);
    localparam logic [31:0]  MAX_N    = 32'(MAX_SAMPLES);

    traj_state_t  state_q;
    traj_state_t  state_d;
    logic [N-1:0] alt_q;
    logic [N-1:0] dist_q;
    logic [31:0]  count_q;
    logic         ovf_q;

    logic [N-1:0] alt_next;
    logic [N-1:0] dist_next;
    logic         alt_sat;
    logic         dist_sat;
    logic [31:0]  count_next;
    logic         launch;
    logic         accept;

    // A start request is honoured in every state except an active ascent.
    assign launch     = start && (state_q != S_ASCEND);
    assign accept     = (state_q == S_ASCEND) && in_valid;
    assign count_next = count_q + 32'd1;

    sat_accum #(
        .W        (N),
        .SUBTRACT (1'b1)
    ) u_alt_accum (
        .acc       (alt_q),
        .add       (fraction_Altitude),
        .sub       (gravity_loss),
        .result    (alt_next),
        .saturated (alt_sat)
    );

    sat_accum #(
        .W        (N),
        .SUBTRACT (1'b0)
    ) u_dist_accum (
        .acc       (dist_q),
        .add       (fraction_Distance),
        .sub       ({N{1'b0}}),
        .result    (dist_next),
        .saturated (dist_sat)
    );

    // State register.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: reaching the target takes priority over timing out.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ASCEND: begin
                if (in_valid) begin
                    if (alt_next >= TARGET_N) begin
                        state_d = S_DONE;
                    end else if (count_next == MAX_N) begin
                        state_d = S_TIMEOUT;
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d = S_ASCEND;
                end
            end
        endcase
    end

    // Accumulators: cleared on launch, updated only on accepted samples.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            alt_q   <= '0;
            dist_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (launch) begin
            alt_q   <= '0;
            dist_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            alt_q   <= alt_next;
            dist_q  <= dist_next;
            count_q <= count_next;
            if (alt_sat || dist_sat) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign current_Altitude = alt_q;
    assign total_Distance   = dist_q;
    assign sample_count     = count_q;
    assign state            = state_q;
    assign overflow         = ovf_q;
    assign done             = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_trajectory_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_trajectory_accumulator
// Brief    : Directed self-checking bench for trajectory_accumulator. A
//            behavioural model tracks the expected outputs with wide
//            arithmetic and is compared every cycle. Literal checks pin
//            the key scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trajectory_accumulator;

    localparam int          N    = 64;
    localparam logic [63:0] TGT  = 64'd188_000_000_000_000;
    localparam int          MAXS = 4;
    localparam logic [63:0] G9   = 64'd1_000_000_000;
    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    localparam int ST_IDLE = 0;
    localparam int ST_ASC  = 1;
    localparam int ST_DONE = 2;
    localparam int ST_TO   = 3;

    logic         clk;
    logic         resetb;
    logic         start;
    logic         in_valid;
    logic [N-1:0] fraction_Altitude;
    logic [N-1:0] fraction_Distance;
    logic [N-1:0] gravity_loss;
    logic [N-1:0] current_Altitude;
    logic [N-1:0] total_Distance;
    logic [31:0]  sample_count;
    logic [1:0]   state;
    logic         done;
    logic         overflow;

    int checks   = 0;
    int failures = 0;

    trajectory_accumulator #(
        .N           (N),
        .TARGET_FX   (TGT),
        .MAX_SAMPLES (MAXS)
    ) dut (
        .clk               (clk),
        .resetb            (resetb),
        .start             (start),
        .in_valid          (in_valid),
        .fraction_Altitude (fraction_Altitude),
        .fraction_Distance (fraction_Distance),
        .gravity_loss      (gravity_loss),
        .current_Altitude  (current_Altitude),
        .total_Distance    (total_Distance),
        .sample_count      (sample_count),
        .state             (state),
        .done              (done),
        .overflow          (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [N-1:0] m_alt;
    logic [N-1:0] m_dist;
    int           m_cnt;
    int           m_state;
    bit           m_ovf;

    always @(posedge clk or negedge resetb) begin : mdl
        logic signed [N+2:0] aw;
        logic [N:0]          dw;
        logic [N-1:0]        na;
        logic [N-1:0]        nd;
        bit                  sat;
        if (!resetb) begin
            m_alt <= '0; m_dist <= '0; m_cnt <= 0; m_state <= ST_IDLE; m_ovf <= 1'b0;
        end else if (m_state != ST_ASC) begin
            if (start) begin
                m_alt <= '0; m_dist <= '0; m_cnt <= 0; m_state <= ST_ASC; m_ovf <= 1'b0;
            end
        end else if (in_valid) begin
            sat = 1'b0;
            aw = $signed({3'b000, m_alt}) + $signed({3'b000, fraction_Altitude})
                 - $signed({3'b000, gravity_loss});
            if (aw < 0) na = '0;
            else if (aw > $signed({3'b000, ALL1})) begin na = ALL1; sat = 1'b1; end
            else na = aw[N-1:0];
            dw = {1'b0, m_dist} + {1'b0, fraction_Distance};
            if (dw > {1'b0, ALL1}) begin nd = ALL1; sat = 1'b1; end
            else nd = dw[N-1:0];
            m_alt  <= na;
            m_dist <= nd;
            m_cnt  <= m_cnt + 1;
            if (sat) m_ovf <= 1'b1;
            if (na >= TGT) m_state <= ST_DONE;
            else if (m_cnt + 1 == MAXS) m_state <= ST_TO;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("cmp_alt",   current_Altitude, m_alt);
        chk("cmp_dist",  total_Distance,   m_dist);
        chk("cmp_count", 64'(sample_count), 64'(m_cnt));
        chk("cmp_state", 64'(state),        64'(m_state));
        chk("cmp_done",  64'(done),         64'(m_state == ST_DONE));
        chk("cmp_ovf",   64'(overflow),     64'(m_ovf));
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit st, input bit v,
                        input logic [63:0] fa, input logic [63:0] fd, input logic [63:0] g);
        @(negedge clk);
        start = st; in_valid = v;
        fraction_Altitude = fa; fraction_Distance = fd; gravity_loss = g;
        @(posedge clk);
        #1;
    endtask

    task automatic go();
        step(1'b1, 1'b0, 64'd0, 64'd0, 64'd0);
    endtask

    initial begin
        resetb = 1'b0; start = 1'b0; in_valid = 1'b0;
        fraction_Altitude = '0; fraction_Distance = '0; gravity_loss = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 64'(state), 64'd0);
        chk("reset_alt",   current_Altitude, 64'd0);
        chk("reset_done",  64'(done), 64'd0);
        @(negedge clk);
        resetb = 1'b1;

        // Three nominal samples, then budget exhausted without target.
        go();
        chk("start_state", 64'(state), 64'(ST_ASC));
        repeat (3) step(1'b0, 1'b1, 10*G9, 5*G9, G9);
        chk("nom_alt",   current_Altitude, 27*G9);
        chk("nom_dist",  total_Distance,   15*G9);
        chk("nom_count", 64'(sample_count), 64'd3);
        chk("nom_state", 64'(state), 64'(ST_ASC));
        step(1'b0, 1'b1, 64'd0, 64'd0, 64'd0);
        chk("to_state", 64'(state), 64'(ST_TO));
        step(1'b0, 1'b1, G9, G9, 64'd0);
        chk("to_ignore_count", 64'(sample_count), 64'd4);

        // Altitude underflow clamps to zero without flagging.
        go();
        chk("restart_count", 64'(sample_count), 64'd0);
        step(1'b0, 1'b1, 2*G9, 64'd0, 64'd0);
        step(1'b0, 1'b1, 64'd0, 64'd0, 5*G9);
        chk("uf_alt", current_Altitude, 64'd0);
        chk("uf_ovf", 64'(overflow), 64'd0);
        repeat (2) step(1'b0, 1'b1, 64'd0, 64'd0, 64'd0);

        // Target reached exactly; later samples ignored.
        go();
        step(1'b0, 1'b1, TGT - 64'd1, 64'd0, 64'd0);
        chk("tgt_m1_state", 64'(state), 64'(ST_ASC));
        step(1'b0, 1'b1, 64'd1, 64'd0, 64'd0);
        chk("tgt_alt",   current_Altitude, TGT);
        chk("tgt_state", 64'(state), 64'(ST_DONE));
        chk("tgt_done",  64'(done), 64'd1);
        step(1'b0, 1'b1, 64'd5, 64'd7, 64'd0);
        chk("done_hold_alt",   current_Altitude, TGT);
        chk("done_hold_count", 64'(sample_count), 64'd2);

        // Fourth sample both hits target and exhausts budget: DONE wins.
        go();
        repeat (4) step(1'b0, 1'b1, 64'd47_000_000_000_000, 64'd1, 64'd0);
        chk("both_state", 64'(state), 64'(ST_DONE));
        chk("both_count", 64'(sample_count), 64'd4);

        // Distance saturation and sticky overflow.
        go();
        step(1'b0, 1'b1, 64'd0, ALL1 - 64'd1, 64'd0);
        step(1'b0, 1'b1, 64'd0, 64'd5, 64'd0);
        chk("sat_dist", total_Distance, ALL1);
        chk("sat_ovf",  64'(overflow), 64'd1);
        step(1'b0, 1'b1, 64'd0, 64'd0, 64'd0);
        chk("sticky_ovf", 64'(overflow), 64'd1);
        step(1'b1, 1'b0, 64'd0, 64'd0, 64'd0);
        chk("asc_start_ignored", 64'(sample_count), 64'd3);
        step(1'b0, 1'b1, 64'd0, 64'd0, 64'd0);
        chk("sat_to_state", 64'(state), 64'(ST_TO));
        chk("sat_to_ovf",   64'(overflow), 64'd1);
        go();
        chk("clr_ovf",  64'(overflow), 64'd0);
        chk("clr_dist", total_Distance, 64'd0);

        // Asynchronous reset between edges during an ascent.
        step(1'b0, 1'b1, 10*G9, G9, 64'd0);
        #2;
        resetb = 1'b0;
        #1;
        chk("areset_state", 64'(state), 64'd0);
        chk("areset_alt",   current_Altitude, 64'd0);
        chk("areset_dist",  total_Distance, 64'd0);
        chk("areset_count", 64'(sample_count), 64'd0);
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        resetb = 1'b1;
        go();
        step(1'b0, 1'b1, 3*G9, G9, 64'd0);
        chk("clean_alt",   current_Altitude, 3*G9);
        chk("clean_dist",  total_Distance, G9);
        chk("clean_count", 64'(sample_count), 64'd1);
        step(1'b0, 1'b0, 64'd0, 64'd0, 64'd0);
        @(negedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
